// File: rtl/breadboard_pkg.sv
// Shared types and constants for the breadboard truth-table sweeper.
package breadboard_pkg;

   localparam int NUM_CODES = 16;
   localparam int F_W       = 10;
   localparam int SIG_W     = 16;
   localparam int CODE_W    = $clog2(NUM_CODES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // One signature step: rotate left by one, then fold in the response vector.
   function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                 input logic [F_W-1:0]   resp);
      return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ {{(SIG_W-F_W){1'b0}}, resp};
   endfunction

endpackage

// File: rtl/breadboard_capture_buf.sv
// 16-entry response capture buffer: synchronous write, asynchronous read,
// asynchronous active-low clear of every entry.
module breadboard_capture_buf
   import breadboard_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [CODE_W-1:0] waddr_i,
   input  logic [F_W-1:0]    wdata_i,
   input  logic [CODE_W-1:0] raddr_i,
   output logic [F_W-1:0]    rdata_o
);

   logic [F_W-1:0] mem_q [NUM_CODES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CODES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read bypasses nothing: a same-cycle write is visible only after its edge.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/breadboard_sweeper.sv
// Steps a 4-bit stimulus code through all 16 values, lets each settle, then
// captures the response vector and folds it into a running signature.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; last code stays on w/x/y/z
//   ST_SETTLE | code held for SETTLE cycles while the block under test settles
//   ST_SAMPLE | one cycle; response captured and signature updated at its end
//   ST_DONE   | one-cycle done pulse after code 15 has been sampled
module breadboard_sweeper
   import breadboard_pkg::*;
#(
   parameter int unsigned SETTLE = 2
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [F_W-1:0]    f,
   output logic              w,
   output logic              x,
   output logic              y,
   output logic              z,
   output logic              busy,
   output logic              done,
   input  logic [CODE_W-1:0] rd_addr,
   output logic [F_W-1:0]    rd_data,
   output logic [SIG_W-1:0]  signature
);

   localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [CODE_W-1:0] CODE_LAST   = CODE_W'(NUM_CODES - 1);

   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q,  code_d;
   logic [3:0]        cnt_q,   cnt_d;
   logic [SIG_W-1:0]  sig_q,   sig_d;
   logic              buf_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      sig_d   = sig_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_SETTLE;
               code_d  = '0;
               cnt_d   = '0;
               sig_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               code_d  = '0;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               code_d  = '0;
               cnt_d   = '0;
            end else begin
               sig_d = sig_step(sig_q, f);
               cnt_d = '0;
               if (code_q == CODE_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SETTLE;
                  code_d  = code_q + CODE_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy   = (state_q != ST_IDLE);
      done   = (state_q == ST_DONE);
      buf_we = (state_q == ST_SAMPLE) && !abort;
   end

   assign w         = code_q[3];
   assign x         = code_q[2];
   assign y         = code_q[1];
   assign z         = code_q[0];
   assign signature = sig_q;

   breadboard_capture_buf u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (buf_we),
      .waddr_i (code_q),
      .wdata_i (f),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed bench for breadboard_sweeper: SETTLE=2 instance for most scenarios,
// SETTLE=1 instance driven by an f1 truth-table model.
module tb_breadboard_sweeper;

   logic       clk;
   logic       rst_n;
   logic       start, abort;
   logic [9:0] f;
   logic       w, x, y, z, busy, done;
   logic [3:0] rd_addr;
   logic [9:0] rd_data;
   logic [15:0] signature;

   logic       start2, abort2;
   logic [9:0] f2;
   logic       w2, x2, y2, z2, busy2, done2;
   logic [3:0] rd_addr2;
   logic [9:0] rd_data2;
   logic [15:0] signature2;

   logic       fmode;
   logic [9:0] fconst;
   logic       f1m;

   int errors = 0;
   int checks = 0;

   breadboard_sweeper #(.SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f),
      .w(w), .x(x), .y(y), .z(z), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_data(rd_data), .signature(signature)
   );

   breadboard_sweeper #(.SETTLE(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .f(f2),
      .w(w2), .x(x2), .y(y2), .z(z2), .busy(busy2), .done(done2),
      .rd_addr(rd_addr2), .rd_data(rd_data2), .signature(signature2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      f = fmode ? fconst : {6'b0, w, x, y, z};
   end

   always_comb begin
      case ({w2, x2, y2, z2})
         4'd5, 4'd6, 4'd10: f1m = 1'b0;
         default:           f1m = 1'b1;
      endcase
      f2 = {8'b0, f1m, 1'b0};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if ({w, x, y, z} !== 4'd0) begin errors++; $display("FAIL reset_code: got %h want 0", {w, x, y, z}); end
      checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL reset_sig: got %h want 0000", signature); end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #0.1;
         checks++; if (rd_data !== 10'h000) begin errors++; $display("FAIL reset_buf[%0d]: got %h want 000", i, rd_data); end
      end
      #1 rst_n = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_loopback();
      logic [15:0] s;
      int ec;
      fmode = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy_e0: got %b want 1", busy); end
      for (int e = 1; e <= 48; e++) begin
         step();
         ec = (e / 3 > 15) ? 15 : e / 3;
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy_e%0d: got %b want 1", e, busy); end
         checks++; if (done !== (e == 48)) begin errors++; $display("FAIL loop_done_e%0d: got %b want %b", e, done, (e == 48)); end
         checks++; if ({w, x, y, z} !== 4'(ec)) begin errors++; $display("FAIL loop_code_e%0d: got %0d want %0d", e, {w, x, y, z}, ec); end
      end
      s = 16'h0000;
      for (int i = 0; i < 16; i++) s = {s[14:0], s[15]} ^ {12'b0, 4'(i)};
      checks++; if (signature !== s) begin errors++; $display("FAIL loop_sig: got %h want %h", signature, s); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_idle_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done_once: got %b want 0", done); end
      checks++; if ({w, x, y, z} !== 4'd15) begin errors++; $display("FAIL loop_code_held: got %0d want 15", {w, x, y, z}); end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #0.1;
         checks++; if (rd_data !== 10'(i)) begin errors++; $display("FAIL loop_buf[%0d]: got %h want %h", i, rd_data, 10'(i)); end
      end
   endtask

   task automatic test_abort();
      logic [15:0] s;
      logic [9:0]  expd;
      fmode  = 1'b1;
      fconst = 10'h3A5;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int e = 1; e <= 17; e++) step();
      checks++; if ({w, x, y, z} !== 4'd5) begin errors++; $display("FAIL abort_pre_code: got %0d want 5", {w, x, y, z}); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++; if ({w, x, y, z} !== 4'd0) begin errors++; $display("FAIL abort_code: got %0d want 0", {w, x, y, z}); end
      s = 16'h0000;
      for (int i = 0; i < 5; i++) s = {s[14:0], s[15]} ^ 16'h03A5;
      checks++; if (signature !== s) begin errors++; $display("FAIL abort_sig: got %h want %h", signature, s); end
      for (int e = 0; e < 6; e++) begin
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done_%0d: got %b want 0", e, done); end
         step();
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         expd = (i < 5) ? 10'h3A5 : 10'(i);
         #0.1;
         checks++; if (rd_data !== expd) begin errors++; $display("FAIL abort_buf[%0d]: got %h want %h", i, rd_data, expd); end
      end
   endtask

   task automatic test_sig_ones();
      fmode  = 1'b1;
      fconst = 10'h001;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int e = 1; e <= 48; e++) step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ones_done: got %b want 1", done); end
      checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL ones_sig: got %h want ffff", signature); end
      abort = 1'b1;
      #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ones_abort_in_done: got %b want 1", done); end
      step();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_idle_busy: got %b want 0", busy); end
      checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL ones_sig_kept: got %h want ffff", signature); end
   endtask

   task automatic test_back_to_back();
      int ndone;
      int done_edge;
      fmode  = 1'b1;
      fconst = 10'h000;
      ndone  = 0;
      done_edge = -1;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int e = 1; e <= 60; e++) begin
         if (e == 10 || e == 30) start = 1'b1;
         step();
         start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            done_edge = e;
         end
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
      checks++; if (done_edge !== 48) begin errors++; $display("FAIL b2b_done_edge: got %0d want 48", done_edge); end
      checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL b2b_sig: got %h want 0000", signature); end
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b want 0", busy); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy2: got %b want 0", busy); end
      checks++; if ({w, x, y, z} !== 4'd15) begin errors++; $display("FAIL start_abort_code: got %0d want 15", {w, x, y, z}); end
   endtask

   task automatic test_f1_settle1();
      logic [15:0] f1_exp;
      f1_exp = 16'hFB9F;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         step();
         checks++; if (done2 !== (e == 32)) begin errors++; $display("FAIL f1_done_e%0d: got %b want %b", e, done2, (e == 32)); end
      end
      step();
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL f1_idle_busy: got %b want 0", busy2); end
      for (int i = 0; i < 16; i++) begin
         rd_addr2 = 4'(i);
         #0.1;
         checks++; if (rd_data2[1] !== f1_exp[i]) begin errors++; $display("FAIL f1_buf[%0d]: got %b want %b", i, rd_data2[1], f1_exp[i]); end
      end
   endtask

   task automatic test_async_reset();
      fmode = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int e = 1; e <= 28; e++) step();
      checks++; if ({w, x, y, z} !== 4'd9) begin errors++; $display("FAIL arst_pre_code: got %0d want 9", {w, x, y, z}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
      checks++; if ({w, x, y, z} !== 4'd0) begin errors++; $display("FAIL arst_code: got %0d want 0", {w, x, y, z}); end
      checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL arst_sig: got %h want 0000", signature); end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #0.1;
         checks++; if (rd_data !== 10'h000) begin errors++; $display("FAIL arst_buf[%0d]: got %h want 000", i, rd_data); end
      end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_hold_done: got %b want 0", done); end
      #2 rst_n = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_release_busy: got %b want 0", busy); end
      for (int e = 0; e < 60; e++) begin
         step();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_no_done_%0d: got %b want 0", e, done); end
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_restart_busy: got %b want 1", busy); end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      start2   = 1'b0;
      abort2   = 1'b0;
      rd_addr  = 4'd0;
      rd_addr2 = 4'd0;
      fmode    = 1'b0;
      fconst   = 10'h000;
      test_reset();
      test_loopback();
      test_abort();
      test_sig_ones();
      test_back_to_back();
      test_f1_settle1();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/breadboard_sweeper.md
BREADBOARD_SWEEPER -- requirements
Module: breadboard_sweeper

Interface
REQ-001 Parameter SETTLE, default 2: cycles each input code is held before its response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  cancel an in-progress sweep.
REQ-006 f  input  10  response vector f[9:0] (f0 = bit 0) from the combinational truth-table block under test.
REQ-007 w, x, y, z  output  1 each  stimulus code bits; w = code[3] (MSB), z = code[0].
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when a full 16-code sweep completes.
REQ-010 rd_addr  input  4  capture-buffer read address.
REQ-011 rd_data  output  10  combinational read of capture-buffer entry rd_addr.
REQ-012 signature  output  16  running response signature of the current or last sweep.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE, start=1, abort=0 at edge E: next state SETTLE, code=0, settle counter=0, signature cleared to 0.
REQ-015 SETTLE SHALL last exactly SETTLE cycles, then go to SAMPLE; code is stable throughout.
REQ-016 SAMPLE SHALL last one cycle; at its closing edge, buf[code] <= f and signature <= {signature[14:0], signature[15]} ^ {6'b0, f}.
REQ-017 SAMPLE with code<15: next state SETTLE, code+1, settle counter=0; code==15: next state DONE, code held at 15.
REQ-018 Each code SHALL be driven for SETTLE+1 cycles; with start accepted at edge 0, done SHALL be high in the cycle after edge 16*(SETTLE+1) (edge 48 for SETTLE=2).
REQ-019 DONE SHALL last one cycle with done=1, then go to IDLE; done is 0 in all other states.
REQ-020 In IDLE, w/x/y/z SHALL keep the last driven code (0 after reset or abort).
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 abort=1 in SETTLE or SAMPLE: next state IDLE, code=0, done not pulsed; entries already written and the partial signature are retained; the pending SAMPLE write is suppressed.
REQ-023 abort in DONE SHALL be ignored (done still pulses); abort and start together in IDLE: abort wins, stays IDLE.
REQ-024 rd_data SHALL reflect buf[rd_addr] combinationally; reading the entry being written returns the old value until after the write edge.
REQ-025 A new sweep SHALL overwrite entries in place; entries are not cleared on start.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, code=0 (w=x=y=z=0), busy=0, done=0, signature=0, settle counter=0, all 16 buffer entries=0.
REQ-027 Reset mid-sweep SHALL discard the sweep with no done pulse; operation resumes from the first rising edge with rst_n high.

Structure
REQ-028 Shared package breadboard_pkg SHALL hold the state enum, NUM_CODES=16, F_W=10, SIG_W=16.
REQ-029 The 16x10 capture buffer SHALL be a sub-module breadboard_capture_buf (write enable, 4-bit write address, async read, async active-low clear).
REQ-030 Total RTL SHALL be 120-400 lines.

Verification
REQ-031 Loopback f={6'b0,code}, SETTLE=2, start pulse -> done at edge 48; rd_data for addr i equals i for i=0..15; busy high for cycles 1..48.
REQ-032 f held at 10'h001 for a whole sweep -> signature=16'hFFFF at done; f held at 10'h000 -> signature=16'h0000.
REQ-033 Abort during the SAMPLE of code 5 -> IDLE next cycle, no done, entries 0..4 written, entry 5 unchanged, w/x/y/z=0.
REQ-034 start re-pulsed at cycles 10 and 30 of a sweep -> ignored; single done at edge 48; start with abort in IDLE -> stays IDLE.
REQ-035 rst_n asserted mid-sweep (code 9), asynchronous to clk -> all outputs and buffer zero immediately; no done.
REQ-036 f driven by a model of the f1 function (0 at codes 5, 6, 10; 1 elsewhere) with SETTLE=1 -> done at edge 32; buffer bit 1 matches the model at all 16 addresses.
